// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: turns a CPU strobe into one
// complete write (AW+W+B) or read (AR+R) transaction.
module axi4_lite_master #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  i_transfer,
    input  logic                  i_write,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_busy,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic [1:0]            o_resp,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic [3:0]            WSTRB,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RVALID,
    output logic                  RREADY
);

    typedef enum logic [2:0] {
        IDLE,
        W_XFER,
        W_RESP,
        R_ADDR,
        R_DATA
    } state_e;

    state_e                state_q, state_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic                  ready_q, ready_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            resp_q, resp_d;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            ready_q   <= 1'b0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            ready_q   <= ready_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        ready_d   = 1'b0;
        awaddr_d  = awaddr_q;
        araddr_d  = araddr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        unique case (state_q)
            IDLE: begin
                if (i_transfer) begin
                    if (i_write) begin
                        awaddr_d  = i_addr;
                        wdata_d   = i_wdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = W_XFER;
                    end else begin
                        araddr_d  = i_addr;
                        arvalid_d = 1'b1;
                        state_d   = R_ADDR;
                    end
                end
            end
            W_XFER: begin
                // AW and W retire independently; leave once both are gone
                if (awvalid_q && AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && WREADY)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) state_d = W_RESP;
            end
            W_RESP: begin
                if (BVALID) begin
                    resp_d  = BRESP;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            R_ADDR: begin
                if (ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = R_DATA;
                end
            end
            R_DATA: begin
                if (RVALID) begin
                    rdata_d = RDATA;
                    resp_d  = RRESP;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_busy  = (state_q != IDLE);
    assign o_ready = ready_q;
    assign o_rdata = rdata_q;
    assign o_resp  = resp_q;
    assign AWADDR  = awaddr_q;
    assign AWVALID = awvalid_q;
    assign WDATA   = wdata_q;
    assign WSTRB   = 4'hF;
    assign WVALID  = wvalid_q;
    assign BREADY  = (state_q == W_RESP);
    assign ARADDR  = araddr_q;
    assign ARVALID = arvalid_q;
    assign RREADY  = (state_q == R_DATA);

endmodule

// File: doc/axi4_lite_master.md
Name: axi4_lite_master

Overview:
Single-outstanding AXI4-Lite master that turns a simple CPU-side request (transfer strobe, write flag, address, write data) into complete AXI4-Lite write or read transactions. It sits directly upstream of the team's AXI4-Lite peripheral slaves (GPIO, etc.), driving their AW/W/B/AR/R channels. It returns read data and the response code to the requester, with a one-cycle done pulse.

Parameters:
ADDR_WIDTH, 4, width of i_addr, AWADDR and ARADDR; 4 bits covers the four-word peripheral register map.
DATA_WIDTH, 32, width of the data bus. Only 32 is supported.

Ports:
ACLK  input  1  system clock; all logic on the rising edge
ARESET  input  1  synchronous reset, active-high
i_transfer  input  1  request strobe; sampled only in IDLE
i_write  input  1  1 = write, 0 = read; captured with i_transfer
i_addr  input  ADDR_WIDTH  byte address; captured with i_transfer
i_wdata  input  32  write data; captured with i_transfer
o_busy  output  1  high whenever state != IDLE
o_ready  output  1  one-cycle done pulse
o_rdata  output  32  read data; valid when o_ready is high after a read, held until the next read completes
o_resp  output  2  BRESP or RRESP of the last transaction; valid with o_ready
AWADDR  output  ADDR_WIDTH  write address
AWVALID  output  1  write address valid
AWREADY  input  1  write address ready
WDATA  output  32  write data
WSTRB  output  4  tied to 4'hF
WVALID  output  1  write data valid
WREADY  input  1  write data ready
BRESP  input  2  write response
BVALID  input  1  write response valid
BREADY  output  1  write response ready
ARADDR  output  ADDR_WIDTH  read address
ARVALID  output  1  read address valid
ARREADY  input  1  read address ready
RDATA  input  32  read data
RRESP  input  2  read response
RVALID  input  1  read data valid
RREADY  output  1  read data ready

Behaviour:
- Reset (ARESET=1 at a clock edge): state goes to IDLE. AWVALID, WVALID, BREADY, ARVALID, RREADY, o_ready and o_busy go to 0. o_rdata, o_resp, AWADDR, ARADDR and WDATA go to 0.
- Reset mid-transaction: the same values apply on the next edge, even with a handshake pending. No done pulse is generated for the aborted transaction.
- States: IDLE, W_XFER, W_RESP, R_ADDR, R_DATA.
- IDLE:
  - On i_transfer=1, the address and data are registered.
  - If i_write=1: next state is W_XFER, and AWVALID and WVALID both go high next cycle.
  - If i_write=0: next state is R_ADDR, and ARVALID goes high next cycle.
- W_XFER: AW and W complete independently.
  - AWVALID drops on the edge where AWVALID&&AWREADY.
  - WVALID drops on the edge where WVALID&&WREADY.
  - When both handshakes are done, go to W_RESP. If both complete in the same cycle, go to W_RESP directly.
  - AWADDR and WDATA stay stable while their valid is high.
- W_RESP: BREADY=1 combinationally in this state.
  - On BVALID, BRESP is captured into o_resp, o_ready pulses for the next cycle, and the state returns to IDLE.
- R_ADDR: ARVALID stays high until ARREADY, then drops on that edge; go to R_DATA.
- R_DATA: RREADY=1 combinationally in this state.
  - On RVALID, RDATA is captured into o_rdata and RRESP into o_resp, o_ready pulses the next cycle, and the state returns to IDLE.
- AXI rules:
  - No valid output may depend combinationally on the corresponding ready.
  - Once asserted, a valid stays high until its handshake completes.
  - Only one transaction is outstanding at a time.
- i_transfer is ignored while o_busy=1. It is not queued.
- o_ready and o_busy=0 coincide in the cycle after completion. A new i_transfer in that same cycle is accepted, giving a 1-cycle IDLE gap between back-to-back transactions.
- A nonzero response (SLVERR=2'b10, DECERR=2'b11) is reported on o_resp only. No retry is performed.

Test Plan:
- Write, slave asserts AWREADY/WREADY 1 cycle after valid and BVALID the cycle after that: i_addr=4'h4, i_wdata=32'h0000_00FF, i_write=1. Expect AWADDR=4'h4, WDATA=32'hFF, WSTRB=4'hF, one BREADY handshake, o_ready pulse with o_resp=2'b00, and o_busy high from request+1 to completion.
- Read, slave returns RDATA=32'h0000_005A with RRESP=2'b00 two cycles after ARREADY: i_addr=4'h8, i_write=0. Expect ARADDR=4'h8, RREADY high only in R_DATA, o_rdata=32'h5A on the o_ready pulse, and o_rdata held afterwards.
- Skewed write, AWREADY at cycle 1 and WREADY at cycle 4: expect AWVALID low from cycle 2 and WVALID held until cycle 4. BREADY must not assert before both handshakes complete.
- Busy rejection plus back-to-back: pulse i_transfer mid-read with a different address and confirm it is ignored. Then issue a write in the o_ready cycle and confirm it is accepted.
- Error response: slave returns BRESP=2'b10. Expect o_resp=2'b10 with o_ready, then return to IDLE.
- Reset mid-read: assert ARESET while ARVALID=1 and ARREADY=0. Expect all valids, readies, o_busy and o_ready at 0 on the next edge, and no o_ready pulse afterwards.
